// File: rtl/gold_ctrl_pkg.sv
// Shared types and constants for the gold-code sequencer and its seed serializers.
package gold_ctrl_pkg;

    localparam int SEED_LEN_DEFAULT = 26;
    localparam int CNT_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    // Width of a counter that has to reach len-1.
    function automatic int fill_width(input int len);
        return $clog2(len);
    endfunction

    localparam int FILL_W = fill_width(SEED_LEN_DEFAULT);

endpackage

// File: rtl/seed_serializer.sv
// Holds one generator seed and presents it MSB first, one bit per fill cycle.
module seed_serializer #(
    parameter int SEED_LEN = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [SEED_LEN-1:0] seed,
    output logic                fill_bit
);

    logic [SEED_LEN-1:0] shreg;

    // The MSB goes straight to the output on load so it is on the wire for the first fill cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg    <= '0;
            fill_bit <= 1'b0;
        end else if (load) begin
            fill_bit <= seed[SEED_LEN-1];
            shreg    <= {seed[SEED_LEN-2:0], 1'b0};
        end else if (shift) begin
            fill_bit <= shreg[SEED_LEN-1];
            shreg    <= {shreg[SEED_LEN-2:0], 1'b0};
        end else begin
            fill_bit <= 1'b0;
            shreg    <= '0;
        end
    end

endmodule

// File: rtl/gold_seq_ctrl.sv
// Sequencer for the paired gold-code generators: seed fill, chip run with hold/stop, done handshake.
module gold_seq_ctrl
    import gold_ctrl_pkg::*;
#(
    parameter int SEED_LEN = SEED_LEN_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stop,
    input  logic                Hold,
    input  logic [SEED_LEN-1:0] Seed_A,
    input  logic [SEED_LEN-1:0] Seed_B,
    input  logic [CNT_W-1:0]    Chip_Count,
    output logic                Enable,
    output logic                Fill_En_A,
    output logic                New_Fill_A,
    output logic                Fill_En_B,
    output logic                New_Fill_B,
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic                Chip_Valid,
    output logic [CNT_W-1:0]    Chip_Index
);

    localparam int FW = fill_width(SEED_LEN);

    state_t           state;
    state_t           next_state;
    logic [FW-1:0]    fill_cnt;
    logic [CNT_W-1:0] n_reg;

    logic             enable_q, fill_en_q, busy_q, done_q, err_q, valid_q;
    logic [CNT_W-1:0] index_q;
    logic             enable_d, fill_en_d, busy_d, done_d, err_d, valid_d;
    logic [CNT_W-1:0] index_d;

    logic seeds_ok, accept, reject, fill_last, last_chip, fill_shift;

    // An all-zero seed would lock its generator, so such a Start is refused.
    assign seeds_ok   = (|Seed_A) && (|Seed_B);
    assign accept     = (state == IDLE) && Start && seeds_ok;
    assign reject     = (state == IDLE) && Start && !seeds_ok;
    assign fill_last  = (fill_cnt == FW'(SEED_LEN - 1));
    assign last_chip  = valid_q && (index_q == n_reg - CNT_W'(1));
    assign fill_shift = (state == FILL) && (next_state == FILL);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            n_reg     <= '0;
            enable_q  <= 1'b0;
            fill_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            index_q   <= '0;
        end else begin
            state     <= next_state;
            fill_cnt  <= fill_shift ? fill_cnt + FW'(1) : '0;
            if (accept) begin
                n_reg <= Chip_Count;
            end
            enable_q  <= enable_d;
            fill_en_q <= fill_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (Stop) begin
                    next_state = IDLE;
                end else if (fill_last) begin
                    next_state = (n_reg == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (Stop) begin
                    next_state = IDLE;
                end else if (last_chip) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every port comes straight off a flop.
    always_comb begin
        enable_d  = 1'b0;
        fill_en_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = reject;
        valid_d   = 1'b0;
        index_d   = '0;
        case (next_state)
            FILL: begin
                enable_d  = 1'b1;
                fill_en_d = 1'b1;
                busy_d    = 1'b1;
            end
            RUN: begin
                busy_d   = 1'b1;
                valid_d  = (state == RUN) ? !Hold : 1'b1;
                enable_d = valid_d;
                if (state == RUN) begin
                    index_d = valid_q ? index_q + CNT_W'(1) : index_q;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    seed_serializer #(.SEED_LEN(SEED_LEN)) u_ser_a (
        .clock    (Clock),
        .reset    (Reset),
        .load     (accept),
        .shift    (fill_shift),
        .seed     (Seed_A),
        .fill_bit (New_Fill_A)
    );

    seed_serializer #(.SEED_LEN(SEED_LEN)) u_ser_b (
        .clock    (Clock),
        .reset    (Reset),
        .load     (accept),
        .shift    (fill_shift),
        .seed     (Seed_B),
        .fill_bit (New_Fill_B)
    );

    assign Enable     = enable_q;
    assign Fill_En_A  = fill_en_q;
    assign Fill_En_B  = fill_en_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Err        = err_q;
    assign Chip_Valid = valid_q;
    assign Chip_Index = index_q;

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// Scoreboard bench for gold_seq_ctrl with a pair of behavioural gold generators driven by its outputs.
module tb_gold_seq_ctrl;

    localparam int SL = 26;
    localparam int CW = 16;

    typedef struct {
        int   kind;
        int   cycle;
        int   index;
        logic chip;
    } ev_t;

    localparam int EV_CHIP = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    ev_t expQ[$];

    logic          Clock = 1'b0;
    logic          Reset, Start, Stop, Hold;
    logic [SL-1:0] Seed_A, Seed_B;
    logic [CW-1:0] Chip_Count;
    logic          Enable, Fill_En_A, New_Fill_A, Fill_En_B, New_Fill_B;
    logic          Busy, Done, Err, Chip_Valid;
    logic [CW-1:0] Chip_Index;

    int cyc = 0;
    int totalChecks = 0;
    int passedChecks = 0;

    logic [SL-1:0] genA = '0;
    logic [SL-1:0] genB = '0;

    gold_seq_ctrl #(.SEED_LEN(SL), .CNT_W(CW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .Hold       (Hold),
        .Seed_A     (Seed_A),
        .Seed_B     (Seed_B),
        .Chip_Count (Chip_Count),
        .Enable     (Enable),
        .Fill_En_A  (Fill_En_A),
        .New_Fill_A (New_Fill_A),
        .Fill_En_B  (Fill_En_B),
        .New_Fill_B (New_Fill_B),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .Chip_Valid (Chip_Valid),
        .Chip_Index (Chip_Index)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Arbitrary generator feedback; chips only need to match between the driven generators and the seed model.
    function automatic logic [SL-1:0] lfsrStep(input logic [SL-1:0] s);
        return {s[SL-2:0], s[SL-1] ^ s[2]};
    endfunction

    always @(posedge Clock) begin
        if (Enable) begin
            genA <= Fill_En_A ? {genA[SL-2:0], New_Fill_A} : lfsrStep(genA);
            genB <= Fill_En_B ? {genB[SL-2:0], New_Fill_B} : lfsrStep(genB);
        end
    end

    function automatic logic [24:0] outVec();
        return {Enable, Fill_En_A, New_Fill_A, Fill_En_B, New_Fill_B,
                Busy, Done, Err, Chip_Valid, Chip_Index};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        totalChecks++;
        if (act === req) passedChecks++;
        else $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic pushEv(input int kind, input int cycle, input int index, input logic chip);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.index = index;
        e.chip  = chip;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Monitor: every Chip_Valid, Done or Err cycle must match the next queued event exactly.
    always @(negedge Clock) begin
        ev_t  e;
        int   kind;
        int   idx;
        logic chip;
        if (Chip_Valid || Done || Err) begin
            kind = Err ? EV_ERR : (Done ? EV_DONE : EV_CHIP);
            idx  = (kind == EV_CHIP) ? int'(Chip_Index) : 0;
            chip = (kind == EV_CHIP) ? (genA[SL-1] ^ genB[SL-1]) : 1'b0;
            totalChecks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, required no event",
                         kind, idx, cyc);
            end else begin
                e = expQ.pop_front();
                if (kind == e.kind && cyc == e.cycle && idx == e.index && chip === e.chip) begin
                    passedChecks++;
                end else begin
                    $display("[TB] FAIL event: got kind %0d cycle %0d idx %0d chip %0b, required kind %0d cycle %0d idx %0d chip %0b",
                             kind, cyc, idx, chip, e.kind, e.cycle, e.index, e.chip);
                end
            end
        end
    end

    // One complete run: Start, checked fill, optional hold window, optional Start pulse during DONE.
    task automatic applyStimulus(input logic [SL-1:0] sa, input logic [SL-1:0] sb, input logic [CW-1:0] n,
                                 input int holdOff, input int holdLen, input bit startInDone);
        int            t;
        int            h;
        int            c;
        logic [SL-1:0] ra;
        logic [SL-1:0] rb;
        Seed_A     = sa;
        Seed_B     = sb;
        Chip_Count = n;
        Start      = 1'b1;
        t  = cyc;
        h  = t + 27 + holdOff;
        c  = t + 27;
        ra = sa;
        rb = sb;
        for (int i = 0; i < int'(n); i++) begin
            while (holdLen > 0 && c > h && c <= h + holdLen) c++;
            pushEv(EV_CHIP, c, i, ra[SL-1] ^ rb[SL-1]);
            ra = lfsrStep(ra);
            rb = lfsrStep(rb);
            c++;
        end
        pushEv(EV_DONE, c, 0, 1'b0);
        tick();
        Start = 1'b0;
        for (int k = 0; k < SL; k++) begin
            checkOutput("fill_outputs", {58'd0, Busy, Enable, Fill_En_A, Fill_En_B, New_Fill_A, New_Fill_B},
                        {58'd0, 4'b1111, sa[SL-1-k], sb[SL-1-k]});
            tick();
        end
        while (cyc <= c) begin
            Hold  = (holdLen > 0 && cyc >= h && cyc < h + holdLen);
            Start = startInDone && (cyc == c);
            tick();
        end
        Hold  = 1'b0;
        Start = 1'b0;
        checkOutput("idle_after_done", {62'd0, Busy, Err}, 64'd0);
        tick();
        checkOutput("idle_after_done2", {62'd0, Busy, Err}, 64'd0);
        tick();
    endtask

    initial begin
        int            t;
        logic [SL-1:0] ra;
        logic [SL-1:0] rb;
        Reset      = 1'b1;
        Start      = 1'b0;
        Stop       = 1'b0;
        Hold       = 1'b0;
        Seed_A     = '0;
        Seed_B     = '0;
        Chip_Count = '0;
        repeat (3) tick();
        checkOutput("reset_outputs", {39'd0, outVec()}, 64'd0);
        Reset = 1'b0;
        tick();
        checkOutput("idle_outputs", {39'd0, outVec()}, 64'd0);

        $display("[TB] basic run N=5");
        applyStimulus(26'h0000001, 26'h2AAAAAA, 16'd5, -1, 0, 1'b0);

        $display("[TB] hold for 3 cycles, N=10");
        applyStimulus(26'h1234567, 26'h0ABCDEF, 16'd10, 3, 3, 1'b0);

        $display("[TB] rejected Start with zero seed");
        Seed_A     = 26'h0000155;
        Seed_B     = '0;
        Chip_Count = 16'd4;
        Start      = 1'b1;
        t = cyc;
        pushEv(EV_ERR, t + 1, 0, 1'b0);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("err_no_busy", {62'd0, Busy, Enable}, 64'd0);
            tick();
        end

        $display("[TB] Stop at fill cycle 10");
        Seed_A     = 26'h3000001;
        Seed_B     = 26'h0F0F0F0;
        Chip_Count = 16'd7;
        Start      = 1'b1;
        t = cyc;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        checkOutput("stop_outputs", {39'd0, outVec()}, 64'd0);
        repeat (3) tick();
        applyStimulus(26'h2222222, 26'h1555555, 16'd3, -1, 0, 1'b0);

        $display("[TB] N=0");
        applyStimulus(26'h0000ACE, 26'h3FFFFFF, 16'd0, -1, 0, 1'b0);

        $display("[TB] reset mid-run, Start during RUN and DONE");
        Seed_A     = 26'h0765432;
        Seed_B     = 26'h1000003;
        Chip_Count = 16'd10;
        Start      = 1'b1;
        t  = cyc;
        ra = Seed_A;
        rb = Seed_B;
        for (int i = 0; i < 5; i++) begin
            pushEv(EV_CHIP, t + 27 + i, i, ra[SL-1] ^ rb[SL-1]);
            ra = lfsrStep(ra);
            rb = lfsrStep(rb);
        end
        tick();
        Start = 1'b0;
        while (cyc < t + 28) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checkOutput("start_in_run_ignored", {62'd0, Busy, Err}, 64'd2);
        while (cyc < t + 31) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checkOutput("reset_mid_run", {39'd0, outVec()}, 64'd0);
        tick();
        applyStimulus(26'h0404040, 26'h2020202, 16'd1, -1, 0, 1'b1);

        repeat (4) tick();
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/gold_seq_ctrl.md
Name: gold_seq_ctrl

Overview:
Sequencer for the two 26-stage gold-code generators (sub_a / sub_b pair).
- On Start it latches two parallel seeds and serially fills both generators.
- It then runs them for a programmed number of chips, with stall (Hold) and abort (Stop) support.
- Done handshake at the end; a per-chip valid/index is provided for downstream chip consumers.

Parameters:
- SEED_LEN, 26: generator length; number of fill cycles; seed width.
- CNT_W, 16: width of Chip_Count and Chip_Index.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request; accepted only in IDLE
- Stop  in  1  abort; returns to IDLE from FILL or RUN, no Done
- Hold  in  1  stall generators; honoured in RUN only
- Seed_A  in  SEED_LEN  seed for generator A; bit i lands in stage i
- Seed_B  in  SEED_LEN  seed for generator B
- Chip_Count  in  CNT_W  chips to generate; sampled with Start
- Enable  out  1  shared generator clock enable
- Fill_En_A  out  1  generator A fill select
- New_Fill_A  out  1  generator A serial fill bit
- Fill_En_B  out  1  generator B fill select
- New_Fill_B  out  1  generator B serial fill bit
- Busy  out  1  high in FILL and RUN
- Done  out  1  one-cycle pulse after last chip
- Err  out  1  one-cycle pulse on a rejected Start
- Chip_Valid  out  1  generator outputs hold a valid chip this cycle
- Chip_Index  out  CNT_W  index of current valid chip, 0..N-1

Behaviour:
- All outputs registered.
- Reset: state IDLE; all outputs 0; counters and seed registers cleared. Reset mid-FILL/RUN aborts immediately, no Done. Generators carry no reset and are fully reseeded on every run.
- FSM states: IDLE, FILL, RUN, DONE.
- IDLE, Start=1, both seeds nonzero:
  - latch Seed_A, Seed_B, Chip_Count (N);
  - go to FILL next cycle.
- IDLE, Start=1, either seed all-zero: stay IDLE; Err=1 for one cycle; nothing latched. An all-zero seed locks the generator.
- Start outside IDLE is ignored, including in DONE.
- FILL, exactly SEED_LEN cycles, fill counter k = 0..25:
  - Enable=1, Fill_En_A=Fill_En_B=1, Busy=1;
  - New_Fill_x = seed_x[SEED_LEN-1-k], i.e. MSB first;
  - Hold is ignored.
  - After the final fill cycle each generator stage i holds seed bit i.
- FILL exit: to RUN, or to DONE if N=0.
- RUN:
  - Fill_En=0; Busy=1; Enable = !Hold.
  - Chip_Valid = !Hold. Chip_Index = chip count, which increments only on valid cycles.
  - The first valid chip equals seed bit SEED_LEN-1 of each generator.
  - When a valid cycle has Chip_Index = N-1, go to DONE; Enable=0 from the next cycle.
- DONE, one cycle: Done=1, Busy=0, Enable=0; then IDLE.
- Stop has priority over all transitions except Reset. From FILL or RUN it goes to IDLE next cycle; Enable, Fill_En, Busy and Chip_Valid drop; no Done.
- Simultaneous Hold and Stop: Stop wins.
- Nominal timing, Start accepted at cycle T, no Hold:
  - FILL at T+1..T+26;
  - Chip_Valid at T+27..T+26+N;
  - Done at T+27+N.
- Chip counter compares against N and never wraps. N = 2^CNT_W-1 is legal.

Decomposition:
- Package gold_ctrl_pkg holds:
  - state enum (IDLE, FILL, RUN, DONE);
  - SEED_LEN default constant;
  - fill-counter width, computed as clog2(SEED_LEN).
- Sub-module seed_serializer, instantiated twice (A, B): parallel load on accept, MSB-first shift during FILL, outputs New_Fill bit.

Test Plan:
- Reset, then Start with Seed_A=26'h0000001, Seed_B=26'h2AAAAAA, N=5 -> Busy T+1..T+31; New_Fill_B pattern 1,0,1,0,... over 26 cycles; Chip_Valid T+27..T+31 with Index 0..4; Done at T+32.
- Hold asserted for 3 cycles mid-RUN, N=10 -> Enable and Chip_Valid low for those 3 cycles; Index continuous; Done delayed by exactly 3 cycles; chips match the reference gold model.
- Start with Seed_B=0 -> Err pulse; Busy stays 0; Enable never asserted.
- Stop at fill cycle 10 -> IDLE next cycle; no Done. A new Start with N=3 then gives a clean 26-cycle fill and 3 chips.
- N=0 -> full 26-cycle fill; no Chip_Valid; Done at T+27.
- Reset asserted mid-RUN; Start pulsed during RUN and DONE -> all outputs 0 after Reset; Starts outside IDLE ignored with no Err.
